ifu_prefetch: RTL and testbench

- Parametrised next-generation instruction fetch unit for the RV32 core. It replaces the single-cycle combinational fetch path.
- Owns the reset synchroniser and the fetch PC. Issues pipelined instruction-memory requests over a valid/ready interface.
- Buffers returned instructions, tagged with their PC, in a FIFO_DEPTH-entry queue. Presents them to the IDU through a valid/ready handshake.
- Handles EXU redirects (jump/trap) by flushing the queue and discarding in-flight responses.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_prefetch_if.sv | 31 +++
 rtl/ifu_fifo.sv | 67 ++++++
 rtl/ifu_prefetch.sv | 122 ++++++++++++
 tb/tb_ifu_prefetch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INST_ALIGN_MASK  : low address bits that must be zero for a 32-bit instruction
//   fetch_entry_t    : one queued instruction tagged with the PC it was fetched from
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Instructions are word aligned; these low bits are cleared on redirect.
    localparam logic [1:0]  INST_ALIGN_MASK  = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// ---------------------------------------------------------------------------
// ifu_prefetch_if
// Bus bundle between the fetch unit, instruction memory and the IDU.
//   imem_req_*  : fetch request (valid/ready, address)
//   imem_rsp_*  : in-order instruction response (always accepted)
//   inst_*      : queue head towards the IDU (valid/ready, instruction, pc)
// Modport master is the fetch unit; slave is the memory/IDU side.
// ---------------------------------------------------------------------------
interface ifu_prefetch_if #(
    parameter int DATA_LEN = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [DATA_LEN-1:0] imem_req_addr;
    logic                imem_rsp_valid;
    logic [DATA_LEN-1:0] imem_rsp_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [DATA_LEN-1:0] inst_out;
    logic [DATA_LEN-1:0] pc_out;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_out,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, pc_out,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Synchronous DEPTH-entry FIFO holding fetched instructions.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   push/push_data : write an entry at the tail
//   pop            : drop the head entry
//   flush          : empty the queue (wins over push and pop)
//   count          : number of stored entries (0..DEPTH)
//   head           : oldest entry (meaningful only while count != 0)
// ---------------------------------------------------------------------------
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is reset as well so the head reads as zero straight out of reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

    // The fetch unit's credit scheme must never push into a full queue.
    fifo_no_overflow: assert property (@(posedge sys_clk) disable iff (!rst_n)
        !(push && !pop && !flush && count == CNT_W'(DEPTH)));

    fifo_no_underflow: assert property (@(posedge sys_clk) disable iff (!rst_n)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
// Pipelined instruction fetch unit for the RV32 core.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   rst_n              : synchronised reset exported to the rest of the core
//   jump_flag, jump_pc : one-cycle redirect request and target from EXU
//   bus (master)       : imem request/response and the IDU instruction stream
// Requests are only issued while count + inflight < FIFO_DEPTH, so every
// response always finds room in the queue.
// ---------------------------------------------------------------------------
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                  DATA_LEN        = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC        = DATA_LEN'(RESET_PC_DEFAULT),
    parameter int                  FIFO_DEPTH      = 4,
    parameter int                  RST_SYNC_STAGES = 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    output logic                rst_n,
    input  logic                jump_flag,
    input  logic [DATA_LEN-1:0] jump_pc,
    ifu_prefetch_if.master      bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_LEN-1:0] pc;
        logic [DATA_LEN-1:0] inst;
    } entry_t;

    logic [RST_SYNC_STAGES-1:0] rst_sync;
    logic [DATA_LEN-1:0]        fetch_pc;
    logic [DATA_LEN-1:0]        rsp_pc;
    logic [DATA_LEN-1:0]        jump_target;
    logic [CNT_W-1:0]           inflight;
    logic [CNT_W-1:0]           inflight_new;
    logic [CNT_W-1:0]           drop_cnt;
    logic [CNT_W-1:0]           count;
    logic [CNT_W:0]             occupancy;
    logic                       req_fire;
    logic                       rsp_push;
    logic                       pop;
    entry_t                     push_entry;
    entry_t                     head;

    // Assert asynchronously, release after RST_SYNC_STAGES clean edges.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n = rst_sync[RST_SYNC_STAGES-1];

    assign jump_target  = jump_pc & ~DATA_LEN'(INST_ALIGN_MASK);
    // Queued entries plus outstanding requests: every slot already promised.
    assign occupancy    = {1'b0, count} + {1'b0, inflight};

    assign bus.imem_req_valid = rst_n & ~jump_flag & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

    assign inflight_new = inflight + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

    // Stale responses after a redirect are swallowed; a response in the
    // redirect cycle itself is discarded by the FIFO flush.
    assign rsp_push   = bus.imem_rsp_valid & (drop_cnt == '0);
    assign push_entry = {rsp_pc, bus.imem_rsp_data};

    assign bus.inst_valid = (count != '0) & ~jump_flag;
    assign pop            = bus.inst_valid & bus.inst_ready;
    assign bus.inst_out   = head.inst;
    assign bus.pc_out     = head.pc;

    // Fetch/response PCs and the outstanding/drop credit counters.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_new;
            if (jump_flag) begin
                fetch_pc <= jump_target;
                rsp_pc   <= jump_target;
                drop_cnt <= inflight_new;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + DATA_LEN'(4);
                end
                if (bus.imem_rsp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end else begin
                        rsp_pc <= rsp_pc + DATA_LEN'(4);
                    end
                end
            end
        end
    end

    ifu_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (jump_flag),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch
// Scoreboard bench for ifu_prefetch. The driver keeps a queue of the
// instructions the IDU should see (sequential PCs from the last reset or
// redirect target, data from the memory model); a negedge monitor pops and
// compares on every IDU handshake and checks request addresses and credits.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;
    import ifu_pkg::*;

    localparam int          DATA_LEN   = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'h8000_0000;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        rst_n;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_pc   = '0;

    ifu_prefetch_if #(.DATA_LEN(DATA_LEN)) bus ();

    ifu_prefetch #(
        .DATA_LEN        (DATA_LEN),
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .RST_SYNC_STAGES (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rst_n     (rst_n),
        .jump_flag (jump_flag),
        .jump_pc   (jump_pc),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int           checks     = 0;
    int           errors     = 0;
    int           accepts    = 0;
    bit           mem_random = 1'b0;
    logic [31:0]  pending[$];
    fetch_entry_t expq[$];
    fetch_entry_t mon_entry;
    logic [31:0]  exp_next_pc = RESET_PC;
    logic [31:0]  exp_req_pc  = RESET_PC;
    bit           prev_stall  = 1'b0;
    logic [31:0]  prev_addr   = '0;

    // Memory contents: a bijective function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic void reseedModel(input logic [31:0] pc);
        expq.delete();
        exp_next_pc = pc;
        exp_req_pc  = pc;
    endfunction

    // One cycle: memory response, handshake inputs, optional redirect.
    task automatic applyStimulus(input bit rreq, input bit iready, input bit jmp,
                                 input logic [31:0] jpc, input bit hold);
        @(posedge sys_clk);
        #1;
        if (!hold && pending.size() > 0 && (!mem_random || $urandom_range(0, 1) == 1)) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memWord(pending.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.imem_req_ready = rreq;
        bus.inst_ready     = iready;
        jump_flag          = jmp;
        jump_pc            = jpc;
        if (jmp) reseedModel(jpc & 32'hFFFF_FFFC);
        while (expq.size() < 16) begin
            expq.push_back('{pc: exp_next_pc, inst: memWord(exp_next_pc)});
            exp_next_pc += 32'd4;
        end
        #1;
    endtask

    task automatic resetDut();
        sys_rst_n          = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        jump_flag          = 1'b0;
        jump_pc            = '0;
        pending.delete();
        reseedModel(RESET_PC);
        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput("reset_rst_n", 32'(rst_n), 32'd0);
        checkOutput("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("reset_req_addr", bus.imem_req_addr, RESET_PC);
        checkOutput("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("reset_inst_out", bus.inst_out, 32'd0);
        checkOutput("reset_pc_out", bus.pc_out, 32'd0);
        #2;
        sys_rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("rst_sync_edge1", 32'(rst_n), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("rst_sync_edge2", 32'(rst_n), 32'd1);
        checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("first_req_addr", bus.imem_req_addr, RESET_PC);
    endtask

    task automatic asyncResetCheck();
        #1;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_n", 32'(rst_n), 32'd0);
        checkOutput("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("async_req_addr", bus.imem_req_addr, RESET_PC);
        checkOutput("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("async_inst_out", bus.inst_out, 32'd0);
        checkOutput("async_pc_out", bus.pc_out, 32'd0);
    endtask

    // Run until the first instruction appears and check it is the target.
    task automatic expectFirst(input string name, input logic [31:0] target);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
            if (bus.inst_valid) begin
                seen = 1'b1;
                checkOutput({name, "_pc"}, bus.pc_out, target);
                checkOutput({name, "_inst"}, bus.inst_out, memWord(target));
            end
        end
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    // Monitor: compares every request accept and every IDU pop.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (jump_flag) begin
                checkOutput("jump_gates_inst_valid", 32'(bus.inst_valid), 32'd0);
                checkOutput("jump_gates_req_valid", 32'(bus.imem_req_valid), 32'd0);
            end else if (prev_stall) begin
                checkOutput("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
                checkOutput("req_hold_addr", bus.imem_req_addr, prev_addr);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                checkOutput("req_addr", bus.imem_req_addr, exp_req_pc);
                exp_req_pc += 32'd4;
                pending.push_back(bus.imem_req_addr);
                accepts++;
                checkOutput("credit_limit", 32'(pending.size() <= FIFO_DEPTH), 32'd1);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_unexpected actual_pc=%h expected=none", bus.pc_out);
                end else begin
                    mon_entry = expq.pop_front();
                    checkOutput("pop_pc", bus.pc_out, mon_entry.pc);
                    checkOutput("pop_inst", bus.inst_out, mon_entry.inst);
                end
            end
            prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        #2;
        resetDut();

        // Backpressure: queue and credits fill, then one pop frees one slot.
        a0 = accepts;
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("bp_accepts", 32'(accepts - a0), 32'd4);
        checkOutput("bp_inst_valid", 32'(bus.inst_valid), 32'd1);
        checkOutput("bp_head_pc", bus.pc_out, RESET_PC);
        checkOutput("bp_head_inst", bus.inst_out, memWord(RESET_PC));
        a0 = accepts;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("bp_one_refill", 32'(accepts - a0), 32'd1);
        expectFirst("bp_stream", RESET_PC + 32'd4);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Redirect with three requests outstanding.
        resetDut();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("redir3_flushed", 32'(bus.inst_valid), 32'd0);
        expectFirst("redir3", 32'h8000_0100);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Redirect coincident with a response and a pop attempt.
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0040, 1'b0);
        checkOutput("coinc_pop_suppressed", 32'(bus.inst_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("coinc_flushed", 32'(bus.inst_valid), 32'd0);
        expectFirst("coinc", 32'h8000_0040);

        // Misaligned redirect target.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0202, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("misaligned_addr", bus.imem_req_addr, 32'h8000_0200);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Randomised traffic, async reset mid-burst, more traffic.
        mem_random = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 39) == 0, $urandom, 1'b0);
        end
        asyncResetCheck();
        resetDut();
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 39) == 0, $urandom, 1'b0);
        end

        // Drain: no new requests, everything outstanding is delivered.
        mem_random = 1'b0;
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("drain_empty", 32'(bus.inst_valid), 32'd0);
        checkOutput("drain_no_pending", 32'(pending.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
